// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one step per clock,
// followed by a single sign-correction cycle that publishes quotient, remainder and flags.
module booth_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic             o_overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state;
   logic             sign_q;
   logic             sign_r;
   logic             dz;
   logic             ov;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dmag;
   logic [WIDTH:0]   rem;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dsr_mag;
   logic [WIDTH+1:0] partial;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // partial is {rem,quo} shifted left by one, seen from the remainder side
   always_comb begin
      dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
      dsr_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
      partial = {rem, quo[WIDTH-1]};
      trial   = partial - {2'b00, dmag};
      q_fix   = sign_q ? -quo : quo;
      r_fix   = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state         <= ST_IDLE;
         sign_q        <= 1'b0;
         sign_r        <= 1'b0;
         dz            <= 1'b0;
         ov            <= 1'b0;
         dvd           <= '0;
         quo           <= '0;
         dmag          <= '0;
         rem           <= '0;
         count         <= '0;
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_div_by_zero <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                  sign_r <= i_dividend[WIDTH-1];
                  dz     <= (i_divisor == '0);
                  ov     <= (i_dividend == MOST_NEG) && (i_divisor == '1);
                  dvd    <= i_dividend;
                  quo    <= dvd_mag;
                  dmag   <= dsr_mag;
                  rem    <= '0;
                  count  <= CW'(WIDTH);
                  o_busy <= 1'b1;
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               rem   <= trial[WIDTH+1] ? partial[WIDTH:0] : trial[WIDTH:0];
               quo   <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
               count <= count - 1'b1;
               if (count == CW'(1)) state <= ST_FIX;
            end
            ST_FIX: begin
               if (dz) begin
                  o_quotient  <= '1;
                  o_remainder <= dvd;
               end else begin
                  o_quotient  <= q_fix;
                  o_remainder <= r_fix;
               end
               o_div_by_zero <= dz;
               o_overflow    <= ov;
               o_done        <= 1'b1;
               o_busy        <= 1'b0;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (WIDTH=4): directed table, control corner cases,
// exhaustive sweep and randomized traffic against an arithmetic reference model.
module tb_booth_divider;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic         overflow;

   int n_chk = 0;
   int n_fail = 0;

   booth_divider #(.WIDTH(W)) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .i_start(start),
      .i_dividend(dividend),
      .i_divisor(divisor),
      .o_quotient(quotient),
      .o_remainder(remainder),
      .o_busy(busy),
      .o_done(done),
      .o_div_by_zero(div_by_zero),
      .o_overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: signed / and % with the zero-divisor and overflow rules layered on top
   function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t v;
      int sa, sb, q, r;
      sa = $signed(a);
      sb = $signed(b);
      v.a = a;
      v.b = b;
      v.dz = 1'b0;
      v.ov = 1'b0;
      if (sb == 0) begin
         q = -1;
         r = sa;
         v.dz = 1'b1;
      end else if (sa == -(1 << (W - 1)) && sb == -1) begin
         q = sa;
         r = 0;
         v.ov = 1'b1;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      v.q = q[W-1:0];
      v.r = r[W-1:0];
      return v;
   endfunction

   task automatic check_result(input string tag, input vec_t e);
      chk({tag, " quotient"}, int'(quotient), int'(e.q));
      chk({tag, " remainder"}, int'(remainder), int'(e.r));
      chk({tag, " div_by_zero"}, int'(div_by_zero), int'(e.dz));
      chk({tag, " overflow"}, int'(overflow), int'(e.ov));
   endtask

   // Issue one divide and wait for done. mode 0: quiet, 1: spurious start sampled at E2,
   // 2: random start noise while busy. Returns with clock at the negedge after done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                         output int lat);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(negedge clk);
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      cyc = 0;
      while (!done && cyc < 20) begin
         if (mode == 1) start = (cyc == 1);
         else if (mode == 2) start = $urandom_range(0, 1) == 1;
         if (start) begin
            dividend = $urandom;
            divisor = $urandom;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      lat = cyc;
   endtask

   task automatic op_and_check(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int mode, input vec_t e);
      int lat;
      run_op(a, b, mode, lat);
      chk({tag, " latency"}, lat, W + 1);
      chk({tag, " busy low in done cycle"}, int'(busy), 0);
      check_result(tag, e);
      @(negedge clk);
      chk({tag, " done single pulse"}, int'(done), 0);
   endtask

   initial begin
      int lat;
      vec_t e;

      vecs[0] = '{a: 4'h7, b: 4'h2, q: 4'h3, r: 4'h1, dz: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 4'h9, b: 4'h2, q: 4'hD, r: 4'hF, dz: 1'b0, ov: 1'b0};
      vecs[2] = '{a: 4'h7, b: 4'hE, q: 4'hD, r: 4'h1, dz: 1'b0, ov: 1'b0};
      vecs[3] = '{a: 4'h9, b: 4'hE, q: 4'h3, r: 4'hF, dz: 1'b0, ov: 1'b0};
      vecs[4] = '{a: 4'h3, b: 4'h5, q: 4'h0, r: 4'h3, dz: 1'b0, ov: 1'b0};
      vecs[5] = '{a: 4'h8, b: 4'hF, q: 4'h8, r: 4'h0, dz: 1'b0, ov: 1'b1};
      vecs[6] = '{a: 4'h8, b: 4'h1, q: 4'h8, r: 4'h0, dz: 1'b0, ov: 1'b0};
      vecs[7] = '{a: 4'h5, b: 4'h0, q: 4'hF, r: 4'h5, dz: 1'b1, ov: 1'b0};
      vecs[8] = '{a: 4'h6, b: 4'h3, q: 4'h2, r: 4'h0, dz: 1'b0, ov: 1'b0};

      repeat (3) @(negedge clk);
      chk("reset quotient", int'(quotient), 0);
      chk("reset remainder", int'(remainder), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset div_by_zero", int'(div_by_zero), 0);
      chk("reset overflow", int'(overflow), 0);
      rst_n = 1'b1;

      // 7/2 with busy traced cycle by cycle
      @(negedge clk);
      start = 1'b1;
      dividend = 4'h7;
      divisor = 4'h2;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("7/2 busy after E%0d", k), int'(busy), 1);
         chk($sformatf("7/2 done after E%0d", k), int'(done), 0);
      end
      @(negedge clk);
      chk("7/2 done after E5", int'(done), 1);
      chk("7/2 busy after E5", int'(busy), 0);
      check_result("7/2 traced", vecs[0]);
      @(negedge clk);
      chk("7/2 done after E6", int'(done), 0);

      for (int i = 0; i < 9; i++)
         op_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 0, vecs[i]);

      // Start pulsed at E2 with other operands must be ignored
      op_and_check("ignored start", 4'h7, 4'h2, 1, vecs[0]);
      chk("ignored start no restart", int'(busy), 0);

      // Back-to-back: second start issued in the done cycle
      run_op(4'h7, 4'h2, 0, lat);
      check_result("b2b first", vecs[0]);
      start = 1'b1;
      dividend = 4'h9;
      divisor = 4'h2;
      lat = 0;
      @(negedge clk);
      start = 1'b0;
      chk("b2b second accepted", int'(busy), 1);
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b second latency", lat, W + 1);
      check_result("b2b second", vecs[1]);

      // Reset asserted before E3 of an operation in flight
      @(negedge clk);
      start = 1'b1;
      dividend = 4'h7;
      divisor = 4'h3;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("midreset quotient", int'(quotient), 0);
      chk("midreset remainder", int'(remainder), 0);
      chk("midreset busy", int'(busy), 0);
      chk("midreset flags", int'({div_by_zero, overflow}), 0);
      lat = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) lat++;
      end
      rst_n = 1'b1;
      chk("midreset no done", lat, 0);
      op_and_check("after reset", 4'h6, 4'h3, 0, vecs[8]);

      // Exhaustive sweep
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            e = model(4'(a), 4'(b));
            op_and_check($sformatf("sweep %0d/%0d", $signed(4'(a)), $signed(4'(b))),
                         4'(a), 4'(b), 0, e);
         end

      // Random operands with start noise while busy
      for (int i = 0; i < 100; i++) begin
         logic [W-1:0] ra, rb;
         ra = 4'($urandom);
         rb = 4'($urandom);
         e = model(ra, rb);
         op_and_check($sformatf("rand%0d %0d/%0d", i, $signed(ra), $signed(rb)), ra, rb, 2, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
